// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl: round-robin multi-approach traffic light sequencer with demand skipping and night blink
module traffic_phase_ctrl #(
    parameter int NUM_DIR      = 4,
    parameter int DIR_W        = 2,
    parameter int CNT_W        = 8,
    parameter int GREEN_TIME   = 10,
    parameter int YELLOW_TIME  = 3,
    parameter int ALL_RED_TIME = 2,
    parameter int BLINK_HALF   = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               day,
    input  logic [NUM_DIR-1:0] req,
    output logic [NUM_DIR-1:0] red,
    output logic [NUM_DIR-1:0] yellow,
    output logic [NUM_DIR-1:0] green,
    output logic [DIR_W-1:0]   active_dir,
    output logic               night
);
    localparam logic [1:0] S_GREEN   = 2'd0;
    localparam logic [1:0] S_YELLOW  = 2'd1;
    localparam logic [1:0] S_ALL_RED = 2'd2;
    localparam logic [1:0] S_NIGHT   = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DIR_W-1:0]   dir_q, dir_d, next_dir;
    logic               blink_q, blink_d;
    logic               g_end, y_end, r_end, b_end;
    logic [NUM_DIR-1:0] dir_bit;

    assign g_end   = cnt_q == CNT_W'(GREEN_TIME - 1);
    assign y_end   = cnt_q == CNT_W'(YELLOW_TIME - 1);
    assign r_end   = cnt_q == CNT_W'(ALL_RED_TIME - 1);
    assign b_end   = cnt_q == CNT_W'(BLINK_HALF - 1);
    assign dir_bit = NUM_DIR'(1) << dir_q;

    // first requesting approach after the current one; scanning downward lets the nearest win, current one last
    always_comb begin
        next_dir = DIR_W'((int'(dir_q) + 1) % NUM_DIR);
        for (int k = NUM_DIR; k >= 1; k--)
            if (req[DIR_W'((int'(dir_q) + k) % NUM_DIR)]) next_dir = DIR_W'((int'(dir_q) + k) % NUM_DIR);
    end

    // phase sequencing; every state change clears the counter, otherwise it counts up
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        dir_d   = dir_q;
        blink_d = blink_q;
        case (state_q)
            S_GREEN: if (!day || g_end) begin
                state_d = S_YELLOW;
                cnt_d   = '0;
            end
            S_YELLOW: if (y_end) begin
                state_d = S_ALL_RED;
                cnt_d   = '0;
            end
            S_ALL_RED: if (r_end) begin
                state_d = day ? S_GREEN : S_NIGHT;
                dir_d   = day ? next_dir : dir_q;
                blink_d = 1'b1;
                cnt_d   = '0;
            end
            default: if (day) begin
                state_d = S_ALL_RED;
                cnt_d   = '0;
            end else if (b_end) begin
                blink_d = ~blink_q;
                cnt_d   = '0;
            end
        endcase
    end

    // state registers; reset parks in all-red just before approach 0 is due
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_ALL_RED;
            cnt_q   <= '0;
            dir_q   <= DIR_W'(NUM_DIR - 1);
            blink_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            blink_q <= blink_d;
        end
    end

    assign green      = state_q == S_GREEN ? dir_bit : '0;
    assign yellow     = state_q == S_NIGHT ? {NUM_DIR{blink_q}} : state_q == S_YELLOW ? dir_bit : '0;
    assign red        = state_q == S_NIGHT ? '0 : state_q == S_ALL_RED ? '1 : ~dir_bit;
    assign active_dir = dir_q;
    assign night      = state_q == S_NIGHT;
endmodule
